// File: rtl/opl3_pkg.sv
// Shared constants and types for the OPL3 operator pipeline.
// Slot numbering is bank-major: slot = bank*NUM_OPS + op.
package opl3_pkg;

    localparam int PHASE_ACC_WIDTH = 20;
    localparam int PHASE_OUT_WIDTH = 10;
    localparam int BANK_NUM_WIDTH  = 1;
    localparam int OP_NUM_WIDTH    = 5;
    localparam int NUM_BANKS       = 2;
    localparam int NUM_OPS         = 18;
    localparam int NUM_SLOTS       = NUM_BANKS * NUM_OPS;
    localparam int SLOT_IDX_WIDTH  = $clog2(NUM_SLOTS);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } acc_state_e;

    typedef struct packed {
        logic                       key;
        logic [PHASE_ACC_WIDTH-1:0] acc;
    } phase_word_t;

    function automatic logic [SLOT_IDX_WIDTH-1:0] slot_idx(
        input logic [BANK_NUM_WIDTH-1:0] bank,
        input logic [OP_NUM_WIDTH-1:0]   op
    );
        return SLOT_IDX_WIDTH'(op) + (bank[0] ? SLOT_IDX_WIDTH'(NUM_OPS) : '0);
    endfunction

endpackage

// File: rtl/op_phase_ram.sv
// Per-slot accumulator store: one write port, one registered read port.
// Read-during-write to the same address returns the old word; the caller bypasses.
module op_phase_ram
    import opl3_pkg::*;
(
    input  logic                      clk,
    input  logic                      we,
    input  logic [SLOT_IDX_WIDTH-1:0] waddr,
    input  phase_word_t               wdata,
    input  logic [SLOT_IDX_WIDTH-1:0] raddr,
    output phase_word_t               rdata
);

    phase_word_t mem [NUM_SLOTS];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/op_phase_acc.sv
// Time-multiplexed per-operator phase accumulator (NCO) with FM offset.
// p0 issues the RAM read, p1 updates and writes back, p2 presents the phase.
module op_phase_acc
    import opl3_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_clk_en,
    input  logic [BANK_NUM_WIDTH-1:0]  bank_num,
    input  logic [OP_NUM_WIDTH-1:0]    op_num,
    input  logic [PHASE_ACC_WIDTH-1:0] phase_inc,
    input  logic                       key_on,
    input  logic [PHASE_OUT_WIDTH-1:0] modulation,
    output logic [PHASE_OUT_WIDTH-1:0] phase_p2,
    output logic                       phase_valid_p2,
    output logic                       init_done
);

    acc_state_e                state, state_nxt;
    logic [SLOT_IDX_WIDTH-1:0] clear_idx, clear_idx_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_CLEAR;
            clear_idx <= '0;
        end else begin
            state     <= state_nxt;
            clear_idx <= clear_idx_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        clear_idx_nxt = clear_idx;
        if (state == ST_CLEAR) begin
            clear_idx_nxt = clear_idx + 1'b1;
            if (clear_idx == SLOT_IDX_WIDTH'(NUM_SLOTS - 1)) begin
                state_nxt     = ST_RUN;
                clear_idx_nxt = '0;
            end
        end
    end

    assign init_done = (state == ST_RUN);

    // p0: accept and address the RAM
    logic                      accept;
    logic [SLOT_IDX_WIDTH-1:0] slot0;
    logic [1:0]                vld_q;
    logic [2:0]                vld_pipe;

    assign slot0    = slot_idx(bank_num, op_num);
    assign accept   = sample_clk_en && (state == ST_RUN) &&
                      (op_num < OP_NUM_WIDTH'(NUM_OPS));
    assign vld_pipe = {vld_q, accept};

    always_ff @(posedge clk) begin
        if (reset)
            vld_q <= '0;
        else
            vld_q <= vld_pipe[1:0];
    end

    logic [SLOT_IDX_WIDTH-1:0]  slot1;
    logic [PHASE_ACC_WIDTH-1:0] inc1;
    logic                       key1;
    logic [PHASE_OUT_WIDTH-1:0] mod1;

    always_ff @(posedge clk) begin
        if (accept) begin
            slot1 <= slot0;
            inc1  <= phase_inc;
            key1  <= key_on;
            mod1  <= modulation;
        end
    end

    // p1: read-modify-write; the previous update is forwarded when it hit the same slot
    phase_word_t                rdata, old_word, new_word, wdata;
    phase_word_t                wr2;
    logic [SLOT_IDX_WIDTH-1:0]  slot2;
    logic [SLOT_IDX_WIDTH-1:0]  waddr;
    logic                       we;
    logic                       key_edge;
    logic [PHASE_ACC_WIDTH-1:0] acc_new;

    assign old_word = (vld_pipe[2] && (slot2 == slot1)) ? wr2 : rdata;
    assign key_edge = key1 & ~old_word.key;
    assign acc_new  = key_edge ? '0 : old_word.acc + inc1;
    assign new_word = '{key: key1, acc: acc_new};

    assign we    = (state == ST_CLEAR) || vld_pipe[1];
    assign waddr = (state == ST_CLEAR) ? clear_idx : slot1;
    assign wdata = (state == ST_CLEAR) ? '0 : new_word;

    op_phase_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (accept ? slot0 : '0),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (vld_pipe[1]) begin
            slot2 <= slot1;
            wr2   <= new_word;
        end
    end

    // p2: output register, holds its value between valid slots
    always_ff @(posedge clk) begin
        if (reset)
            phase_p2 <= '0;
        else if (vld_pipe[1])
            phase_p2 <= acc_new[PHASE_ACC_WIDTH-1 -: PHASE_OUT_WIDTH] + mod1;
    end

    assign phase_valid_p2 = vld_pipe[2];

endmodule

// File: tb/tb_op_phase_acc.sv
// Directed plus random stimulus against a slot-level reference model of the accumulator.
module tb_op_phase_acc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_clk_en = 1'b0;
    logic [0:0]  bank_num = '0;
    logic [4:0]  op_num = '0;
    logic [19:0] phase_inc = '0;
    logic        key_on = 1'b0;
    logic [9:0]  modulation = '0;
    logic [9:0]  phase_p2;
    logic        phase_valid_p2;
    logic        init_done;

    always #5 clk = ~clk;

    op_phase_acc dut (
        .clk            (clk),
        .reset          (reset),
        .sample_clk_en  (sample_clk_en),
        .bank_num       (bank_num),
        .op_num         (op_num),
        .phase_inc      (phase_inc),
        .key_on         (key_on),
        .modulation     (modulation),
        .phase_p2       (phase_p2),
        .phase_valid_p2 (phase_valid_p2),
        .init_done      (init_done)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // reference model: per-slot accumulator and key history
    int unsigned m_acc [36];
    bit          m_prev [36];
    bit          m_run = 1'b0;
    int          m_clr = 0;
    bit          pend_v = 1'b0;
    int unsigned pend_ph = 0;
    int unsigned last_ph = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit rst, input bit en, input bit bank, input logic [4:0] op,
                        input logic [19:0] inc, input bit key, input logic [9:0] md);
        bit          exp_v;
        int unsigned exp_ph;
        bit          acc;
        int          slot;
        reset         = rst;
        sample_clk_en = en;
        bank_num      = bank;
        op_num        = op;
        phase_inc     = inc;
        key_on        = key;
        modulation    = md;

        exp_v  = pend_v;
        exp_ph = pend_v ? pend_ph : last_ph;
        acc    = en && !rst && m_run && (op < 18);
        pend_v = acc;
        if (acc) begin
            slot = (bank ? 18 : 0) + int'(op);
            if (key && !m_prev[slot])
                m_acc[slot] = 0;
            else
                m_acc[slot] = (m_acc[slot] + inc) % (1 << 20);
            m_prev[slot] = key;
            pend_ph = ((m_acc[slot] / 1024) + md) % 1024;
        end
        if (rst) begin
            exp_v  = 1'b0;
            exp_ph = 0;
            pend_v = 1'b0;
            m_run  = 1'b0;
            m_clr  = 0;
            for (int i = 0; i < 36; i++) begin
                m_acc[i]  = 0;
                m_prev[i] = 1'b0;
            end
        end else if (!m_run) begin
            m_clr++;
            if (m_clr == 36)
                m_run = 1'b1;
        end
        last_ph = exp_ph;

        @(posedge clk);
        @(negedge clk);
        chk("valid", 32'(phase_valid_p2), 32'(exp_v));
        chk("phase", 32'(phase_p2), exp_ph);
        chk("init_done", 32'(init_done), 32'(m_run));
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 5'd0, 20'd0, 1'b0, 10'd0);
    endtask

    task automatic rand_tick(input bit rst);
        tick(rst, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 19)), 20'($urandom), $urandom_range(0, 3) != 0,
             10'($urandom));
    endtask

    initial begin
        int cyc;
        // reset, then strobes during the clear sweep must be ignored
        tick(1'b1, 1'b0, 1'b0, 5'd0, 20'd0, 1'b0, 10'd0);
        tick(1'b1, 1'b1, 1'b0, 5'd0, 20'h400, 1'b1, 10'd0);
        cyc = 0;
        while (!m_run) begin
            tick(1'b0, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 17)),
                 20'($urandom), 1'b1, 10'($urandom));
            cyc++;
        end
        chk("clear_len", 32'(cyc), 32'd36);

        // slot (0,0): rising edge then steady accumulation
        for (int i = 0; i < 5; i++)
            tick(1'b0, 1'b1, 1'b0, 5'd0, 20'h400, 1'b1, 10'd0);
        idle();
        chk("acc_seq_last", 32'(phase_p2), 32'd4);
        for (int i = 5; i < 1025; i++)
            tick(1'b0, 1'b1, 1'b0, 5'd0, 20'h400, 1'b1, 10'd0);
        idle();
        chk("phase_wrap", 32'(phase_p2), 32'd0);

        // back-to-back on (1,17) with (0,3) interleaved
        for (int i = 0; i < 3; i++)
            tick(1'b0, 1'b1, 1'b1, 5'd17, 20'h800, 1'b1, 10'd0);
        tick(1'b0, 1'b1, 1'b0, 5'd3, 20'h1400, 1'b1, 10'd0);
        tick(1'b0, 1'b1, 1'b1, 5'd17, 20'h800, 1'b1, 10'd0);
        tick(1'b0, 1'b1, 1'b0, 5'd3, 20'h1400, 1'b1, 10'd0);
        tick(1'b0, 1'b1, 1'b1, 5'd17, 20'h800, 1'b1, 10'd0);
        idle();
        chk("bypass_b1o17", 32'(phase_p2), 32'd8);

        // modulation wrap both directions
        tick(1'b0, 1'b1, 1'b0, 5'd5, 20'h0, 1'b1, 10'd0);
        tick(1'b0, 1'b1, 1'b0, 5'd5, 20'(1020 * 1024), 1'b1, 10'd10);
        idle();
        chk("mod_pos", 32'(phase_p2), 32'd6);
        tick(1'b0, 1'b1, 1'b0, 5'd6, 20'h0, 1'b1, 10'd0);
        tick(1'b0, 1'b1, 1'b0, 5'd6, 20'(5 * 1024), 1'b1, 10'h3F8);
        idle();
        chk("mod_neg", 32'(phase_p2), 32'd1021);

        // key toggle on (0,7), then an invalid op must not disturb anything
        tick(1'b0, 1'b1, 1'b0, 5'd7, 20'h0, 1'b1, 10'd0);
        tick(1'b0, 1'b1, 1'b0, 5'd7, 20'(50 * 1024), 1'b1, 10'd0);
        tick(1'b0, 1'b1, 1'b0, 5'd7, 20'h400, 1'b0, 10'd0);
        idle();
        chk("key_off_acc", 32'(phase_p2), 32'd51);
        tick(1'b0, 1'b1, 1'b0, 5'd7, 20'h400, 1'b1, 10'd0);
        tick(1'b0, 1'b1, 1'b0, 5'd18, 20'h400, 1'b0, 10'd0);
        tick(1'b0, 1'b1, 1'b1, 5'd18, 20'h400, 1'b1, 10'd0);
        chk("op18_novalid", 32'(phase_valid_p2), 32'd0);
        chk("key_rise_zero", 32'(phase_p2), 32'd0);
        tick(1'b0, 1'b1, 1'b0, 5'd7, 20'h400, 1'b1, 10'd0);
        idle();
        chk("after_op18", 32'(phase_p2), 32'd1);

        // random traffic
        for (int i = 0; i < 400; i++)
            rand_tick(1'b0);

        // reset with strobes in flight, sweep again, restart from zero
        tick(1'b0, 1'b1, 1'b0, 5'd0, 20'h400, 1'b1, 10'd0);
        tick(1'b1, 1'b1, 1'b0, 5'd0, 20'h400, 1'b1, 10'd0);
        while (!m_run)
            rand_tick(1'b0);
        tick(1'b0, 1'b1, 1'b0, 5'd0, 20'h400, 1'b1, 10'd3);
        idle();
        chk("post_reset", 32'(phase_p2), 32'd3);
        for (int i = 0; i < 200; i++)
            rand_tick(1'b0);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
